// File: rtl/debug_dump_sequencer_pkg.sv
// debug_dump_sequencer_pkg: shared states, ASCII constants and nibble-to-hex helper for the debug dump
// Contents: package debug_pkg with state_e, CHAR_SP/CHAR_CR/CHAR_LF and hex_ascii()
package debug_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        CAPT,
        HI,
        LO,
        SP,
        CR,
        LF,
        DONE
    } state_e;

    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// debug_dump_sequencer_if: shared memory read port and UART byte stream of the debug dump
// Signals: core_req/core_addr (1-Wire core claim), mem_addr/mem_rd_data (sync read port),
//          tx_data/tx_valid/tx_ready (valid/ready byte stream to the UART)
// Modports: master = dump sequencer, slave = memory, core and UART side
interface debug_dump_sequencer_if #(
    parameter int ADDR_W = 7
);

    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  core_req, core_addr, mem_rd_data, tx_ready,
        output mem_addr, tx_data, tx_valid
    );

    modport slave (
        output core_req, core_addr, mem_rd_data, tx_ready,
        input  mem_addr, tx_data, tx_valid
    );

endinterface

// File: rtl/debug_dump_sequencer_edge.sv
// dbg_edge_pending: registers memoryUpdated, detects its rising edge and keeps a coalescing pending flag
// Ports: clk, nRst (async active-low), level_i (memoryUpdated), busy_i (dump in progress),
//        clr_i (pending consumed), edge_o (rising edge seen this cycle), pending_o (edge seen while busy)
module dbg_edge_pending (
    input  logic clk,
    input  logic nRst,
    input  logic level_i,
    input  logic busy_i,
    input  logic clr_i,
    output logic edge_o,
    output logic pending_o
);

    logic sample_q, prev_q, pending_q, pending_d;

    assign edge_o    = sample_q & ~prev_q;
    assign pending_o = pending_q;

    // Clear wins: the cycle that consumes pending also consumes any edge arriving with it.
    always_comb pending_d = clr_i ? 1'b0 : (edge_o & busy_i) ? 1'b1 : pending_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sample_q  <= 1'b0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sample_q  <= level_i;
            prev_q    <= sample_q;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: dumps the memory array as uppercase hex text lines over a valid/ready UART stream
// Ports: clk, nRst (async active-low), memoryUpdated (rising edge requests a dump),
//        dump_busy (dump in progress), bus (master side of debug_dump_sequencer_if)
module debug_dump_sequencer
    import debug_pkg::*;
#(
    parameter int MEM_DEPTH      = 128,
    parameter int ADDR_W         = 7,
    parameter int BYTES_PER_LINE = 8
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  memoryUpdated,
    output logic                  dump_busy,
    debug_dump_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] BPL       = ADDR_W'(BYTES_PER_LINE);
    localparam logic [ADDR_W-1:0] BPL_LAST  = ADDR_W'(BYTES_PER_LINE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              edge_s, pending_s, clr_s;

    dbg_edge_pending u_edge (
        .clk      (clk),
        .nRst     (nRst),
        .level_i  (memoryUpdated),
        .busy_i   (dump_busy),
        .clr_i    (clr_s),
        .edge_o   (edge_s),
        .pending_o(pending_s)
    );

    // The 1-Wire core always owns the read port when it asks for it.
    assign bus.mem_addr = bus.core_req ? bus.core_addr : addr_q;
    assign dump_busy    = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_d       = byte_q;
        clr_s        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (edge_s) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: state_d = bus.core_req ? FETCH : CAPT;
            // Data belongs to the address issued in FETCH, so a core claim now cannot corrupt it.
            CAPT: begin
                byte_d  = bus.mem_rd_data;
                state_d = HI;
            end
            HI: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = hex_ascii(byte_q[7:4]);
                if (bus.tx_ready) state_d = LO;
            end
            LO: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = hex_ascii(byte_q[3:0]);
                if (bus.tx_ready) state_d = ((addr_q % BPL) == BPL_LAST) ? CR : SP;
            end
            SP: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = CHAR_SP;
                if (bus.tx_ready) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = FETCH;
                end
            end
            CR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = CHAR_CR;
                if (bus.tx_ready) state_d = LF;
            end
            LF: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = CHAR_LF;
                if (bus.tx_ready) begin
                    addr_d  = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;
                    state_d = (addr_q == LAST_ADDR) ? DONE : FETCH;
                end
            end
            DONE: begin
                if (pending_s || edge_s) begin
                    clr_s   = 1'b1;
                    addr_d  = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb_debug_dump_sequencer: self-checking bench for debug_dump_sequencer with a behavioural memory and UART sink
module tb_debug_dump_sequencer;

    localparam int DEPTH = 128;
    localparam int FULL  = 400;

    logic clk = 1'b0;
    logic nRst;
    logic memoryUpdated;
    logic dump_busy;
    logic [7:0] mem [DEPTH];
    logic [7:0] q [$];
    logic [7:0] exp_q [$];
    string hx = "0123456789ABCDEF";
    int checks = 0;
    int errors = 0;
    int falls = 0;
    bit rnd = 1'b0;

    typedef struct {
        logic [7:0] val;
        bit         rnd;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;
    vec_t vt [6];

    debug_dump_sequencer_if #(.ADDR_W(7)) bif ();

    debug_dump_sequencer #(.MEM_DEPTH(128), .ADDR_W(7), .BYTES_PER_LINE(8)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .memoryUpdated(memoryUpdated),
        .dump_busy    (dump_busy),
        .bus          (bif.master)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        bif.mem_rd_data <= mem[bif.mem_addr];
    end

    initial forever begin
        @(negedge clk);
        if (rnd) bif.tx_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // UART sink: collects accepted bytes, checks hold-stable, counts dump_busy falls
    initial begin
        logic pv, pr, pb;
        logic [7:0] pd;
        pv = 0; pr = 0; pb = 0; pd = 0;
        forever begin
            @(posedge clk);
            if (!nRst) begin
                pv = 0; pb = 0;
            end else begin
                if (pv && !pr) chk("hold", 32'({bif.tx_valid, bif.tx_data}), 32'({1'b1, pd}));
                if (bif.tx_valid && bif.tx_ready) q.push_back(bif.tx_data);
                if (pb && !dump_busy) falls++;
                pv = bif.tx_valid; pr = bif.tx_ready; pd = bif.tx_data; pb = dump_busy;
            end
        end
    end

    task automatic mk_exp();
        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back(hx[mem[a][7:4]]);
            exp_q.push_back(hx[mem[a][3:0]]);
            if (a % 8 == 7) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else begin
                exp_q.push_back(8'h20);
            end
        end
    endtask

    task automatic cmp_stream(input string nm, input int reps);
        int bad;
        bad = -1;
        chk({nm, "_len"}, q.size(), reps * FULL);
        for (int i = 0; i < q.size() && i < reps * FULL; i++)
            if (bad < 0 && q[i] !== exp_q[i % FULL]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data: index %0d got %0h expected %0h", nm, bad, q[bad], exp_q[bad % FULL]);
        end
    endtask

    task automatic pulse();
        @(negedge clk); memoryUpdated = 1'b1;
        repeat (3) @(negedge clk);
        memoryUpdated = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string nm);
        int n;
        n = 0;
        while (dump_busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dump_busy !== lvl) chk({nm, "_timeout"}, 32'(dump_busy), 32'(lvl));
    endtask

    task automatic wait_chars(input int cnt, input int budget, input string nm);
        int n;
        n = 0;
        while (q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() < cnt) chk({nm, "_timeout"}, q.size(), cnt);
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
    endtask

    initial begin
        vt[0] = '{8'hAF, 1'b1, 8'h41, 8'h46};
        vt[1] = '{8'h00, 1'b0, 8'h30, 8'h30};
        vt[2] = '{8'h9A, 1'b1, 8'h39, 8'h41};
        vt[3] = '{8'hFF, 1'b0, 8'h46, 8'h46};
        vt[4] = '{8'h5C, 1'b1, 8'h35, 8'h43};
        vt[5] = '{8'h3E, 1'b1, 8'h33, 8'h45};

        nRst = 1'b0;
        memoryUpdated = 1'b0;
        bif.core_req = 1'b0;
        bif.core_addr = '0;
        bif.tx_ready = 1'b0;
        fill_ramp();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bif.tx_valid), 0);
        chk("rst_data", 32'(bif.tx_data), 0);
        chk("rst_busy", 32'(dump_busy), 0);
        nRst = 1'b1;
        bif.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_valid", 32'(bif.tx_valid), 0);

        // Ramp dump with UART always ready
        q.delete(); mk_exp();
        pulse();
        wait_busy(1'b1, 20, "ramp_start");
        wait_busy(1'b0, 5000, "ramp_end");
        cmp_stream("ramp", 1);
        chk("ramp_busy", 32'(dump_busy), 0);

        // Table: byte at addr 0, with and without random back-pressure
        for (int v = 0; v < 6; v++) begin
            fill_ramp();
            mem[0] = vt[v].val;
            mk_exp();
            q.delete();
            rnd = vt[v].rnd;
            pulse();
            wait_busy(1'b1, 20, "vec_start");
            wait_busy(1'b0, 8000, "vec_end");
            rnd = 1'b0;
            @(negedge clk);
            bif.tx_ready = 1'b1;
            chk($sformatf("vec%0d_hi", v), 32'(q.size() > 0 ? q[0] : 8'hXX), 32'(vt[v].hi));
            chk($sformatf("vec%0d_lo", v), 32'(q.size() > 1 ? q[1] : 8'hXX), 32'(vt[v].lo));
            cmp_stream($sformatf("vec%0d", v), 1);
        end

        // Core holds the port during FETCH of addr 5
        fill_ramp(); mk_exp(); q.delete();
        pulse();
        wait_chars(15, 200, "core_pre");
        bif.core_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bif.core_addr = 7'(100 + i);
            #1;
            chk("core_mux", 32'(bif.mem_addr), 32'(100 + i));
            @(negedge clk);
        end
        chk("core_stall", q.size(), 15);
        bif.core_req = 1'b0;
        #1;
        chk("core_release_mux", 32'(bif.mem_addr), 5);
        wait_busy(1'b0, 5000, "core_end");
        cmp_stream("core", 1);

        // Three pulses during a dump coalesce into one extra dump
        q.delete(); falls = 0;
        pulse();
        wait_chars(30, 200, "coal_pre");
        repeat (3) pulse();
        wait_busy(1'b0, 10000, "coal_end");
        cmp_stream("coal", 2);
        chk("coal_falls", falls, 1);

        // Async reset mid-dump, with a pending request outstanding
        q.delete();
        pulse();
        wait_chars(20, 200, "rst_pre");
        pulse();
        wait_chars(50, 200, "rst_50");
        nRst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bif.tx_valid), 0);
        chk("rst_mid_busy", 32'(dump_busy), 0);
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        q.delete();
        repeat (300) @(negedge clk);
        chk("rst_quiet_len", q.size(), 0);
        chk("rst_quiet_busy", 32'(dump_busy), 0);
        pulse();
        wait_busy(1'b1, 20, "rst_re_start");
        wait_busy(1'b0, 5000, "rst_re_end");
        cmp_stream("rst_re", 1);

        // Level held high is one edge
        q.delete();
        @(negedge clk); memoryUpdated = 1'b1;
        repeat (1000) @(negedge clk);
        memoryUpdated = 1'b0;
        wait_busy(1'b0, 5000, "held_end");
        repeat (50) @(negedge clk);
        cmp_stream("held", 1);
        chk("held_busy", 32'(dump_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
